// File: rtl/pktgen_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pktgen_pkg
// Brief    : Shared constants, header byte offsets and FSM states for udp_pktgen
// Revision : 1.0 - initial release
// ============================================================================
package pktgen_pkg;

    localparam logic [15:0] MIN_FRAME_LEN  = 16'd60;
    localparam logic [15:0] ETH_HDR_LEN    = 16'd14;
    localparam logic [15:0] ETH_IP_HDR_LEN = 16'd34;

    localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_TTL         = 8'd64;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

    // Byte offsets from the start of the frame
    localparam int OFF_ETH_DST   = 0;
    localparam int OFF_ETH_SRC   = 6;
    localparam int OFF_ETH_TYPE  = 12;
    localparam int OFF_IP_VER    = 14;
    localparam int OFF_IP_TOTLEN = 16;
    localparam int OFF_IP_TTL    = 22;
    localparam int OFF_IP_PROTO  = 23;
    localparam int OFF_IP_CSUM   = 24;
    localparam int OFF_IP_SADDR  = 26;
    localparam int OFF_IP_DADDR  = 30;
    localparam int OFF_UDP_SPORT = 34;
    localparam int OFF_UDP_DPORT = 36;
    localparam int OFF_UDP_LEN   = 38;
    localparam int OFF_SEQ       = 42;
    localparam int OFF_TS        = 46;

    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                              input logic [15:0] max_len);
        if (len < MIN_FRAME_LEN)
            return MIN_FRAME_LEN;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ipv4_csum.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ipv4_csum
// Brief    : Registered IPv4 header checksum for a given frame length
// Revision : 1.0 - initial release
// ============================================================================
module ipv4_csum
    import pktgen_pkg::*;
#(
    parameter logic [31:0] SADDR = 32'hC0A8_016F,
    parameter logic [31:0] DADDR = 32'hC0A8_017A
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic        en_i,
    input  logic [15:0] len_i,
    output logic [15:0] csum_o
);

    logic [15:0] w_tot_len;
    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic [15:0] csum_q;

    assign w_tot_len = len_i - ETH_HDR_LEN;

    // id, frag and the checksum field itself contribute zero
    assign w_sum = 20'({IP_VER_IHL, 8'h00}) + 20'(w_tot_len)
                 + 20'({IP_TTL, IP_PROTO_UDP})
                 + 20'(SADDR[31:16]) + 20'(SADDR[15:0])
                 + 20'(DADDR[31:16]) + 20'(DADDR[15:0]);

    assign w_fold1 = {1'b0, w_sum[15:0]} + {13'b0, w_sum[19:16]};
    assign w_fold2 = w_fold1[15:0] + {15'b0, w_fold1[16]};

    always_ff @(posedge clk156) begin
        if (reset)
            csum_q <= '0;
        else if (en_i)
            csum_q <= ~w_fold2;
    end

    assign csum_o = csum_q;

endmodule
`default_nettype wire

// File: rtl/udp_pktgen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : udp_pktgen
// Brief    : AXI-Stream 64-bit UDP/IPv4 test frame generator with sequence no.
//            Optional macro UDP_PKTGEN_TS_EN adds ts_in timestamp at bytes 46-53.
// Revision : 1.0 - initial release
// ============================================================================
module udp_pktgen
    import pktgen_pkg::*;
#(
    parameter logic [47:0] ETH_DST       = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] ETH_SRC       = 48'h00_11_22_33_44_55,
    parameter logic [31:0] IP_SADDR      = 32'hC0A8_016F,
    parameter logic [31:0] IP_DADDR      = 32'hC0A8_017A,
    parameter logic [15:0] UDP_SPORT     = 16'd3776,
    parameter logic [15:0] UDP_DPORT     = 16'd3776,
    parameter logic [15:0] MAX_FRAME_LEN = 16'd1514
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic        cfg_en,
    input  logic [15:0] cfg_frame_len,
    input  logic [31:0] cfg_gap,
    input  logic [31:0] cfg_count,
`ifdef UDP_PKTGEN_TS_EN
    input  logic [63:0] ts_in,
`endif
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic [31:0] pkt_cnt
);

    state_t      state_q,   state_d;
    logic [15:0] len_q,     len_d;
    logic [31:0] gap_q,     gap_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [12:0] beat_q,    beat_d;
    logic [31:0] seq_q,     seq_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] run_cnt_q, run_cnt_d;

    logic [15:0]  w_len_clamped;
    logic [15:0]  w_nbeats;
    logic         w_last_beat;
    logic         w_send;
    logic [15:0]  w_csum;
    logic [15:0]  w_tot_len;
    logic [15:0]  w_udp_len;
    logic [511:0] w_hdr;
    logic [63:0]  w_data;
    logic [7:0]   w_keep_last;

    assign w_len_clamped = clamp_len(cfg_frame_len, MAX_FRAME_LEN);
    assign w_nbeats      = (len_q + 16'd7) >> 3;
    assign w_last_beat   = ({3'b0, beat_q} == (w_nbeats - 16'd1));
    assign w_send        = (state_q == ST_SEND);
    assign w_tot_len     = len_q - ETH_HDR_LEN;
    assign w_udp_len     = len_q - ETH_IP_HDR_LEN;
    assign w_keep_last   = (len_q[2:0] == 3'd0) ? 8'hFF
                                                : (8'hFF >> (4'd8 - {1'b0, len_q[2:0]}));

    ipv4_csum #(
        .SADDR (IP_SADDR),
        .DADDR (IP_DADDR)
    ) u_csum (
        .clk156 (clk156),
        .reset  (reset),
        .en_i   (state_q == ST_LOAD),
        .len_i  (w_len_clamped),
        .csum_o (w_csum)
    );

`ifdef UDP_PKTGEN_TS_EN
    logic [63:0] ts_q;

    always_ff @(posedge clk156) begin
        if (reset)
            ts_q <= '0;
        else if (w_send && m_axis_tready && (beat_q == 13'd0))
            ts_q <= ts_in;
    end
`endif

    // Header image; byte n lives at w_hdr[8n +: 8], everything unset is zero
    always_comb begin
        w_hdr = '0;
        for (int i = 0; i < 6; i++) begin
            w_hdr[8*(OFF_ETH_DST+i) +: 8] = ETH_DST[8*(5-i) +: 8];
            w_hdr[8*(OFF_ETH_SRC+i) +: 8] = ETH_SRC[8*(5-i) +: 8];
        end
        for (int i = 0; i < 2; i++) begin
            w_hdr[8*(OFF_ETH_TYPE+i)  +: 8] = ETH_TYPE_IPV4[8*(1-i) +: 8];
            w_hdr[8*(OFF_IP_TOTLEN+i) +: 8] = w_tot_len[8*(1-i) +: 8];
            w_hdr[8*(OFF_IP_CSUM+i)   +: 8] = w_csum[8*(1-i) +: 8];
            w_hdr[8*(OFF_UDP_SPORT+i) +: 8] = UDP_SPORT[8*(1-i) +: 8];
            w_hdr[8*(OFF_UDP_DPORT+i) +: 8] = UDP_DPORT[8*(1-i) +: 8];
            w_hdr[8*(OFF_UDP_LEN+i)   +: 8] = w_udp_len[8*(1-i) +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            w_hdr[8*(OFF_IP_SADDR+i) +: 8] = IP_SADDR[8*(3-i) +: 8];
            w_hdr[8*(OFF_IP_DADDR+i) +: 8] = IP_DADDR[8*(3-i) +: 8];
            w_hdr[8*(OFF_SEQ+i)      +: 8] = seq_q[8*(3-i) +: 8];
        end
`ifdef UDP_PKTGEN_TS_EN
        for (int i = 0; i < 8; i++)
            w_hdr[8*(OFF_TS+i) +: 8] = ts_q[8*(7-i) +: 8];
`endif
        w_hdr[8*OFF_IP_VER   +: 8] = IP_VER_IHL;
        w_hdr[8*OFF_IP_TTL   +: 8] = IP_TTL;
        w_hdr[8*OFF_IP_PROTO +: 8] = IP_PROTO_UDP;
    end

    always_comb begin
        w_data = '0;
        if (beat_q < 13'd8)
            w_data = w_hdr[64*int'(beat_q[2:0]) +: 64];
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        beat_d    = beat_q;
        seq_d     = seq_q;
        pkt_cnt_d = pkt_cnt_q;
        run_cnt_d = run_cnt_q;
        case (state_q)
            ST_IDLE: begin
                run_cnt_d = '0;
                if (cfg_en)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                len_d   = w_len_clamped;
                gap_d   = cfg_gap;
                seq_d   = pkt_cnt_q;
                beat_d  = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    if (w_last_beat) begin
                        beat_d    = '0;
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        run_cnt_d = run_cnt_q + 32'd1;
                        gap_cnt_d = '0;
                        if ((cfg_count != 32'd0) && (run_cnt_d == cfg_count))
                            state_d = ST_DONE;
                        else if (!cfg_en)
                            state_d = ST_IDLE;
                        else if (gap_q == 32'd0)
                            state_d = ST_LOAD;
                        else
                            state_d = ST_GAP;
                    end else begin
                        beat_d = beat_q + 13'd1;
                    end
                end
            end
            ST_GAP: begin
                if (!cfg_en)
                    state_d = ST_IDLE;
                else if (gap_cnt_q == gap_q - 32'd1)
                    state_d = ST_LOAD;
                else
                    gap_cnt_d = gap_cnt_q + 32'd1;
            end
            ST_DONE: begin
                if (!cfg_en)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= MIN_FRAME_LEN;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            beat_q    <= '0;
            seq_q     <= '0;
            pkt_cnt_q <= '0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            beat_q    <= beat_d;
            seq_q     <= seq_d;
            pkt_cnt_q <= pkt_cnt_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign m_axis_tvalid = w_send;
    assign m_axis_tdata  = w_send ? w_data : 64'd0;
    assign m_axis_tkeep  = w_send ? (w_last_beat ? w_keep_last : 8'hFF) : 8'h00;
    assign m_axis_tlast  = w_send && w_last_beat;
    assign busy          = (state_q != ST_IDLE);
    assign pkt_cnt       = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_pktgen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_udp_pktgen
// Brief    : Self-checking bench for udp_pktgen against a byte-array frame model
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_pktgen;

    logic        clk156 = 1'b0;
    logic        reset;
    logic        cfg_en;
    logic [15:0] cfg_frame_len;
    logic [31:0] cfg_gap;
    logic [31:0] cfg_count;
    logic        m_axis_tready;
    logic        m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        busy;
    logic [31:0] pkt_cnt;
`ifdef UDP_PKTGEN_TS_EN
    logic [63:0] ts_in;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int change_at_beat = -1;
    logic [63:0] ts_next = 64'd0;
    logic [7:0]  exp_frm [0:2047];
    logic [7:0]  cap     [0:63];

    always #3 clk156 = ~clk156;

    udp_pktgen dut (
        .clk156        (clk156),
        .reset         (reset),
        .cfg_en        (cfg_en),
        .cfg_frame_len (cfg_frame_len),
        .cfg_gap       (cfg_gap),
        .cfg_count     (cfg_count),
`ifdef UDP_PKTGEN_TS_EN
        .ts_in         (ts_in),
`endif
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .pkt_cnt       (pkt_cnt)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int l);
        if (l < 60)   return 60;
        if (l > 1514) return 1514;
        return l;
    endfunction

    function automatic logic [7:0] last_keep(input int l);
        if (l % 8 == 0) return 8'hFF;
        return 8'((1 << (l % 8)) - 1);
    endfunction

    task automatic put_be(input int off, input int nbytes, input logic [63:0] v);
        for (int i = 0; i < nbytes; i++)
            exp_frm[off+i] = v[8*(nbytes-1-i) +: 8];
    endtask

    // Reference frame built byte-by-byte from the header field layout
    task automatic build_frame(input int l, input logic [31:0] seq);
        logic [31:0] s;
        for (int i = 0; i < 2048; i++) exp_frm[i] = 8'h00;
        put_be(0,  6, 64'hFFFF_FFFF_FFFF);
        put_be(6,  6, 64'h0011_2233_4455);
        put_be(12, 2, 64'h0800);
        exp_frm[14] = 8'h45;
        put_be(16, 2, 64'(l - 14));
        exp_frm[22] = 8'd64;
        exp_frm[23] = 8'd17;
        put_be(26, 4, 64'hC0A8_016F);
        put_be(30, 4, 64'hC0A8_017A);
        put_be(34, 2, 64'd3776);
        put_be(36, 2, 64'd3776);
        put_be(38, 2, 64'(l - 34));
        put_be(42, 4, 64'(seq));
        s = 32'd0;
        for (int i = 0; i < 10; i++) s += {16'd0, exp_frm[14+2*i], exp_frm[15+2*i]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        put_be(24, 2, 64'(~s[15:0]));
    endtask

    // Called at a negedge; returns at the negedge after the last beat's acceptance
    task automatic recv_frame(input int l_req, input int rdy_pct, output int idle);
        int l, nb, b, guard;
        logic [63:0] ev, mk, pd;
        logic [8:0]  pkl;
        bit          have_prev;
        logic [31:0] s;
        l  = clamp(l_req);
        nb = (l + 7) / 8;
        build_frame(l, 32'(exp_cnt));
`ifdef UDP_PKTGEN_TS_EN
        ts_in = ts_next;
`endif
        idle = 0;
        while (!m_axis_tvalid && idle < 400) begin
            idle++;
            @(negedge clk156);
        end
        chk("frame_start", 64'(m_axis_tvalid), 64'd1);
        if (!m_axis_tvalid) return;
        b = 0; guard = 0; have_prev = 0; pd = '0; pkl = '0;
        while (b < nb && guard < 5000) begin
            guard++;
            chk("tvalid_hold", 64'(m_axis_tvalid), 64'd1);
            if (!m_axis_tvalid) return;
            if (have_prev) begin
                chk("stall_tdata", m_axis_tdata, pd);
                chk("stall_ctl", 64'({m_axis_tkeep, m_axis_tlast}), 64'(pkl));
            end
            m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
            if (m_axis_tready) begin
                ev = '0; mk = '0;
                for (int k = 0; k < 8; k++) begin
                    if (8*b + k < l) begin
                        ev[8*k +: 8] = exp_frm[8*b+k];
                        mk[8*k +: 8] = 8'hFF;
                    end
                end
                if (b < 8)
                    for (int k = 0; k < 8; k++) cap[8*b+k] = m_axis_tdata[8*k +: 8];
                chk("tdata", m_axis_tdata & mk, ev);
                chk("tkeep", 64'(m_axis_tkeep), 64'((b == nb-1) ? last_keep(l) : 8'hFF));
                chk("tlast", 64'(m_axis_tlast), 64'(b == nb-1));
`ifdef UDP_PKTGEN_TS_EN
                if (b == 0) put_be(46, 8, ts_in);
`endif
                if (b == change_at_beat) begin
                    cfg_en = 1'b0;
                    cfg_frame_len = 16'd500;
                    cfg_gap = 32'd0;
                end
                b++;
                have_prev = 0;
            end else begin
                pd = m_axis_tdata;
                pkl = {m_axis_tkeep, m_axis_tlast};
                have_prev = 1;
            end
            @(negedge clk156);
`ifdef UDP_PKTGEN_TS_EN
            if (b >= 1) ts_in = {$urandom, $urandom};
`endif
        end
        chk("frame_beats", 64'(b), 64'(nb));
        s = 32'd0;
        for (int i = 0; i < 10; i++) s += {16'd0, cap[14+2*i], cap[15+2*i]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        chk("ip_csum_verify", 64'(s[15:0]), 64'hFFFF);
        exp_cnt++;
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
        ts_next = {$urandom, $urandom};
    endtask

    task automatic run_single(input int l, input int pct);
        int idle;
        cfg_frame_len = 16'(l);
        cfg_count = 32'd1;
        cfg_gap = 32'd0;
        cfg_en = 1'b1;
        recv_frame(l, pct, idle);
        repeat (3) @(negedge clk156);
        chk("done_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        cfg_en = 1'b0;
        repeat (2) @(negedge clk156);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_en = 1'b0;
        repeat (2) @(negedge clk156);
        reset = 1'b0;
        exp_cnt = 0;
        @(negedge clk156);
    endtask

    initial begin
        int idle;
        int cnt;
        int w;
        reset = 1'b1;
        cfg_en = 1'b0;
        cfg_frame_len = 16'd60;
        cfg_gap = 32'd0;
        cfg_count = 32'd0;
        m_axis_tready = 1'b0;
`ifdef UDP_PKTGEN_TS_EN
        ts_in = 64'd0;
`endif
        repeat (3) @(negedge clk156);
        reset = 1'b0;
        @(negedge clk156);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

        // Length boundaries with back-to-back ready
        run_single(60, 100);
        run_single(61, 100);
        run_single(64, 100);
        run_single(1514, 100);
        run_single(40, 100);
        run_single(2000, 100);

        // Backpressure on random lengths
        for (int i = 0; i < 6; i++) run_single(int'($urandom_range(400, 60)), 50);
        run_single(1514, 50);

        // cfg_en dropped and cfg changed mid-frame: frame completes unaltered
        cfg_count = 32'd0;
        cfg_gap = 32'd5;
        cfg_frame_len = 16'd100;
        cfg_en = 1'b1;
        change_at_beat = 2;
        recv_frame(100, 70, idle);
        change_at_beat = -1;
        repeat (10) @(negedge clk156);
        chk("drop_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("drop_busy", 64'(busy), 64'd0);

        // Unlimited mode gap, then cfg_en low while in GAP
        cfg_count = 32'd0;
        cfg_gap = 32'd3;
        cfg_frame_len = 16'd72;
        cfg_en = 1'b1;
        recv_frame(72, 100, idle);
        recv_frame(72, 100, idle);
        chk("gap3_idle", 64'(idle), 64'd4);
        cfg_en = 1'b0;
        repeat (3) @(negedge clk156);
        chk("gap_drop_busy", 64'(busy), 64'd0);
        chk("gap_drop_tvalid", 64'(m_axis_tvalid), 64'd0);

        // Counted run from reset: three frames, seq 0..2, 11 idle cycles apart
        do_reset();
        cfg_count = 32'd3;
        cfg_gap = 32'd10;
        cfg_frame_len = 16'(int'($urandom_range(120, 60)));
        cfg_en = 1'b1;
        recv_frame(int'(cfg_frame_len), 100, idle);
        recv_frame(int'(cfg_frame_len), 100, idle);
        chk("gap10_idle_1", 64'(idle), 64'd11);
        recv_frame(int'(cfg_frame_len), 100, idle);
        chk("gap10_idle_2", 64'(idle), 64'd11);
        repeat (20) @(negedge clk156);
        chk("count3_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("count3_busy", 64'(busy), 64'd1);
        chk("count3_pkt_cnt", 64'(pkt_cnt), 64'd3);
        cfg_en = 1'b0;
        repeat (2) @(negedge clk156);
        chk("count3_idle", 64'(busy), 64'd0);

        // Reset while beat 4 is on the bus
        cfg_count = 32'd0;
        cfg_gap = 32'd0;
        cfg_frame_len = 16'd200;
        cfg_en = 1'b1;
        m_axis_tready = 1'b1;
        cnt = 0;
        w = 0;
        while (cnt < 4 && w < 400) begin
            @(negedge clk156);
            w++;
            if (m_axis_tvalid) cnt++;
        end
        @(negedge clk156);
        chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
        reset = 1'b1;
        cfg_en = 1'b0;
        @(posedge clk156);
        #1;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk156);
        reset = 1'b0;
        exp_cnt = 0;
        @(negedge clk156);
        run_single(200, 100);

`ifdef UDP_PKTGEN_TS_EN
        ts_next = 64'h0123_4567_89AB_CDEF;
        run_single(60, 100);
        chk("ts_bytes", {cap[46], cap[47], cap[48], cap[49], cap[50], cap[51], cap[52], cap[53]},
            64'h0123_4567_89AB_CDEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
